// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler: blank / show per digit, with a double-buffered
// hex value behind a valid/ready load port so a frame never shows mixed old/new digits.
module seg7_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int TICK_DIV     = 200_000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [4*N_DIGITS-1:0]       in_data,
    input  logic [N_DIGITS-1:0]         in_dp,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N_DIGITS-1:0]         an,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx,
    output logic                        frame_start
);
    localparam int DW = $clog2(N_DIGITS);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITS - 1);
    localparam logic [PW-1:0] TICK_MAX   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLANK_MAX  = BW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

    state_t                         r_state, w_nxt_state;
    logic [DW-1:0]                  r_digit, w_nxt_digit;
    logic [PW-1:0]                  r_presc, w_nxt_presc;
    logic [BW-1:0]                  r_blank, w_nxt_blank;
    logic [N_DIGITS-1:0][3:0]       r_active, r_pend;
    logic [N_DIGITS-1:0]            r_active_dp, r_pend_dp;
    logic                           r_pend_vld;
    logic [N_DIGITS-1:0]            r_an, w_an;
    logic [6:0]                     r_seg, w_seg;
    logic                           r_dp, w_dp;
    logic                           r_frame, w_frame;
    logic                           w_xfer;

    function automatic logic [6:0] f_hexdec(input logic [3:0] n);
        case (n)
            4'h0: f_hexdec = 7'b1000000;
            4'h1: f_hexdec = 7'b1111001;
            4'h2: f_hexdec = 7'b0100100;
            4'h3: f_hexdec = 7'b0110000;
            4'h4: f_hexdec = 7'b0011001;
            4'h5: f_hexdec = 7'b0010010;
            4'h6: f_hexdec = 7'b0000010;
            4'h7: f_hexdec = 7'b1111000;
            4'h8: f_hexdec = 7'b0000000;
            4'h9: f_hexdec = 7'b0010000;
            4'hA: f_hexdec = 7'b0001000;
            4'hB: f_hexdec = 7'b0000011;
            4'hC: f_hexdec = 7'b1000110;
            4'hD: f_hexdec = 7'b0100001;
            4'hE: f_hexdec = 7'b0000110;
            default: f_hexdec = 7'b0001110;
        endcase
    endfunction

    // Next state plus the registered pin values for that next state, so pins change
    // on the same edge as the state.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_digit = r_digit;
        w_nxt_presc = r_presc;
        w_nxt_blank = r_blank;
        w_frame     = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            OFF: begin
                w_nxt_digit = '0;
                w_xfer      = 1'b1;
                if (en) begin
                    w_nxt_state = BLANK;
                    w_nxt_blank = '0;
                    w_frame     = 1'b1;
                end
            end
            BLANK: begin
                if (!en) begin
                    w_nxt_state = OFF;
                    w_nxt_digit = '0;
                end else if (r_blank == BLANK_MAX) begin
                    w_nxt_state = SHOW;
                    w_nxt_presc = '0;
                end else begin
                    w_nxt_blank = r_blank + 1'b1;
                end
            end
            SHOW: begin
                if (!en) begin
                    w_nxt_state = OFF;
                    w_nxt_digit = '0;
                end else if (r_presc == TICK_MAX) begin
                    w_nxt_state = BLANK;
                    w_nxt_blank = '0;
                    if (r_digit == LAST_DIGIT) begin
                        w_nxt_digit = '0;
                        w_frame     = 1'b1;
                        w_xfer      = 1'b1;
                    end else begin
                        w_nxt_digit = r_digit + 1'b1;
                    end
                end else begin
                    w_nxt_presc = r_presc + 1'b1;
                end
            end
            default: begin
                w_nxt_state = OFF;
                w_nxt_digit = '0;
            end
        endcase

        w_an  = '1;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        // The active buffer never changes on a BLANK->SHOW edge, so reading it here is safe.
        if (w_nxt_state == SHOW) begin
            w_an[w_nxt_digit] = 1'b0;
            w_seg             = f_hexdec(r_active[w_nxt_digit]);
            w_dp              = ~r_active_dp[w_nxt_digit];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= OFF;
            r_digit     <= '0;
            r_presc     <= '0;
            r_blank     <= '0;
            r_active    <= '0;
            r_active_dp <= '0;
            r_pend      <= '0;
            r_pend_dp   <= '0;
            r_pend_vld  <= 1'b0;
            r_an        <= '1;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_frame     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_digit <= w_nxt_digit;
            r_presc <= w_nxt_presc;
            r_blank <= w_nxt_blank;
            r_an    <= w_an;
            r_seg   <= w_seg;
            r_dp    <= w_dp;
            r_frame <= w_frame;
            if (in_valid && !r_pend_vld) begin
                r_pend     <= in_data;
                r_pend_dp  <= in_dp;
                r_pend_vld <= 1'b1;
            end else if (w_xfer && r_pend_vld) begin
                r_active    <= r_pend;
                r_active_dp <= r_pend_dp;
                r_pend_vld  <= 1'b0;
            end
        end
    end

    assign in_ready    = ~r_pend_vld;
    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign digit_idx   = r_digit;
    assign frame_start = r_frame;
endmodule
